mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that executes the R-type mult, multu, div and divu operations decoded by the main control and ALU-control stages.
- Owns the architectural HI/LO registers and raises busy so the datapath can stall while an operation is in flight.
- Sits in the execute stage beside the ALU. It takes rs/rt operands from the register file and provides HI/LO for mfhi/mflo writeback.

Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- wr_hi  in  1  mthi write strobe
- wr_lo  in  1  mtlo write strobe
- wr_data  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight; datapath stalls
- done  out  1  one-cycle pulse when HI/LO update from an operation
- div_by_zero  out  1  sticky flag; set by div/divu with rt=0; cleared by the next accepted start
- hi  out  WIDTH  HI register (remainder / upper product)
- lo  out  WIDTH  LO register (quotient / lower product)

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs including mid-operation):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0.
- FSM states:
  - IDLE: start=1 at edge E0 latches operands, op and sign info → CALC. busy=1 after E0. Exception: div/divu with rt_val=0 → ZDIV.
  - CALC: one shift-add (mult) or restoring shift-subtract (div) step per edge on operand magnitudes. The counter runs 0..WIDTH-1. The edge with counter=WIDTH-1 → FIX.
  - FIX: one edge applies sign correction and loads hi/lo. Sets done=1, busy=0 → IDLE.
  - ZDIV: one edge loads hi=rs_val, lo=all-ones and sets div_by_zero=1, done=1, busy=0 → IDLE.
- Latency:
  - Normal operation: hi/lo valid, done=1, busy=0 immediately after edge E0+WIDTH+1 (E0+33 for WIDTH=32).
  - Divide by zero: after E0+1.
- done is high for exactly one cycle. It clears on the following edge.
- Back-to-back: start may be asserted in the cycle where done=1 (state is IDLE). It is accepted at that edge.
- Signed rules:
  - mult: product sign = sign(rs) XOR sign(rt). FIX negates the 2·WIDTH result if negative.
  - div: quotient negative if operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (no trap).
  - Magnitudes are computed on WIDTH+1 bits internally so the most-negative value is handled.
- Unsigned ops: no sign conversion or correction.
- Ignored inputs:
  - start while busy=1 is ignored; it is not queued.
  - wr_hi/wr_lo while busy=1 are ignored.
- mthi/mtlo in IDLE:
  - wr_hi/wr_lo update hi/lo at the next edge; both may write in the same cycle.
  - If start and wr_* are asserted in the same IDLE cycle, start wins and the write is dropped.
- hi/lo hold their values throughout CALC. They change only on FIX, ZDIV, mthi/mtlo or reset.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11
  - state encoding IDLE/CALC/FIX/ZDIV
  - iteration constant derived from WIDTH
- Sub-module mdu_iter_step (combinational): one shift-add or shift-subtract step selected by an is_div bit. The FSM, counter and HI/LO registers stay in mult_div_unit.

Test Plan:
- mult rs=7, rt=0xFFFFFFFD → at E0+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse of 1 cycle. busy high E0+1..E0+32.
- multu rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then divu 100/7 started in the done cycle → hi=2, lo=14 33 cycles later.
- div rs=0xFFFFFFF9 (−7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- div rs=0x00001234, rt=0 → at E0+1: hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1, done=1. The next mult start clears div_by_zero.
- Start mult. At iteration 10 assert start (op=div) and wr_hi=1 with wr_data=0xDEAD → both ignored, original product delivered. Repeat with reset at iteration 10 → next cycle busy=0, done=0, hi=lo=0.
- In IDLE assert wr_hi=1 with wr_data=0xAAAA5555 and wr_lo=1 → hi=lo=0xAAAA5555 next edge. Assert start together with wr_lo → write dropped, operation runs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and helpers that derive the iteration count from WIDTH.
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      ZDIV = 2'd3
   } mdu_state_t;

   // One shift step per operand bit.
   function automatic int mdu_iters(input int width);
      return width;
   endfunction

   function automatic int mdu_cnt_bits(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the unit: shift-add for multiply, restoring
// shift-subtract for divide, both on unsigned magnitudes.
module mdu_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH:0]   operand,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum     = rem_in + (q_in[0] ? operand : '0);
      shifted = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
      diff    = {1'b0, shifted} - {1'b0, operand};
      rem_out = '0;
      q_out   = '0;
      if (is_div) begin
         // A borrow out of the trial subtraction means the divisor did not fit.
         if (diff[WIDTH+1]) begin
            rem_out = shifted;
            q_out   = {q_in[WIDTH-2:0], 1'b0};
         end else begin
            rem_out = diff[WIDTH:0];
            q_out   = {q_in[WIDTH-2:0], 1'b1};
         end
      end else begin
         rem_out = {1'b0, sum[WIDTH:1]};
         q_out   = {sum[0], q_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative mult/multu/div/divu unit owning the HI/LO registers; raises busy
// while an operation is in flight so the execute stage can stall.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       dbg_state
);

   localparam int ITERS = mdu_iters(WIDTH);
   localparam int CW    = mdu_cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   mdu_state_t state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH:0]   opnd_q;
   logic             is_div_q, neg_p_q, neg_r_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, dbz_q;

   logic             sgn, rs_neg, rt_neg, rt_zero;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH:0]   rt_ext, rt_mag;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_q;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Handshake: start is taken only when busy=0 (state IDLE); busy stays high
   // until the edge that loads HI/LO, and done pulses for exactly that one cycle.
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign dbg_state   = state_q;

   // The multiplier/dividend magnitude fits unsigned in WIDTH bits even for the
   // most-negative value; the divisor/multiplicand uses WIDTH+1.
   always_comb begin
      sgn     = op_is_signed(op);
      rs_neg  = sgn & rs_val[WIDTH-1];
      rt_neg  = sgn & rt_val[WIDTH-1];
      rt_zero = (rt_val == '0);
      rs_mag  = rs_neg ? -rs_val : rs_val;
      rt_ext  = {rt_neg, rt_val};
      rt_mag  = rt_neg ? -rt_ext : rt_ext;
   end

   mdu_iter_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .rem_in  (rem_q),
      .q_in    (q_q),
      .operand (opnd_q),
      .rem_out (step_rem),
      .q_out   (step_q)
   );

   always_comb begin
      prod     = {rem_q[WIDTH-1:0], q_q};
      prod_fix = neg_p_q ? -prod : prod;
      quo_fix  = neg_p_q ? -q_q : q_q;
      rem_fix  = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = (op_is_div(op) && rt_zero) ? ZDIV : CALC;
         CALC: if (cnt_q == LAST) state_d = FIX;
         FIX:  state_d = IDLE;
         ZDIV: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         neg_p_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  dbz_q    <= 1'b0;
                  cnt_q    <= '0;
                  rem_q    <= '0;
                  is_div_q <= op_is_div(op);
                  neg_p_q  <= rs_neg ^ rt_neg;
                  neg_r_q  <= rs_neg;
                  opnd_q   <= rt_mag;
                  // A zero divisor keeps the raw dividend so ZDIV can return it in HI.
                  q_q      <= (op_is_div(op) && rt_zero) ? rs_val : rs_mag;
               end else begin
                  if (wr_hi) hi_q <= wr_data;
                  if (wr_lo) lo_q <= wr_data;
               end
            end
            CALC: begin
               rem_q <= step_rem;
               q_q   <= step_q;
               cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            end
            FIX: begin
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               done_q <= 1'b1;
            end
            ZDIV: begin
               hi_q   <= q_q;
               lo_q   <= '1;
               dbz_q  <= 1'b1;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency,
// busy/done timing, divide-by-zero, ignored inputs, mid-operation reset.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        wr_hi, wr_lo;
   logic [31:0] wr_data;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;
   logic [1:0]  dbg_state;

   int tests = 0;
   int fails = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .rs_val      (rs_val),
      .rt_val      (rt_val),
      .wr_hi       (wr_hi),
      .wr_lo       (wr_lo),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo),
      .dbg_state   (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after the accepting edge E0; lat counts edges since E0.
   task automatic wait_done(output int lat, output int bsy);
      lat = 0;
      bsy = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bsy++;
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bsy);
      op     = o;
      rs_val = a;
      rt_val = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_done(lat, bsy);
   endtask

   int lat, bsy;

   initial begin
      reset = 1'b1; start = 1'b0; op = MDU_MULT; rs_val = '0; rt_val = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
      tick(); tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_state", dbg_state, 0);
      reset = 1'b0;
      tick();

      // signed mult 7 * -3 = -21
      run_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD, lat, bsy);
      check("mult_lat", lat, 33);
      check("mult_busy_cycles", bsy, 33);
      check("mult_busy_low", busy, 0);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFEB);
      tick();
      check("mult_done_pulse", done, 0);

      // multu max*max, then divu started in the done cycle
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
      check("b2b_done_seen", done, 1);
      run_op(MDU_DIVU, 32'd100, 32'd7, lat, bsy);
      check("divu_lat", lat, 33);
      check("divu_hi", hi, 32'd2);
      check("divu_lo", lo, 32'd14);

      // signed divides
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bsy);
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bsy);
      check("div_min_lo", lo, 32'h8000_0000);
      check("div_min_hi", hi, 32'h0000_0000);
      run_op(MDU_DIV, 32'd100, 32'hFFFF_FFF9, lat, bsy);
      check("div_negdiv_lo", lo, 32'hFFFF_FFF2);
      check("div_negdiv_hi", hi, 32'd2);

      // divide by zero
      run_op(MDU_DIV, 32'h0000_1234, 32'd0, lat, bsy);
      check("zdiv_lat", lat, 1);
      check("zdiv_hi", hi, 32'h0000_1234);
      check("zdiv_lo", lo, 32'hFFFF_FFFF);
      check("zdiv_flag", div_by_zero, 1);
      check("zdiv_busy", busy, 0);
      tick();
      check("zdiv_flag_sticky", div_by_zero, 1);
      run_op(MDU_DIVU, 32'hFFFF_FFFB, 32'd0, lat, bsy);
      check("zdivu_hi", hi, 32'hFFFF_FFFB);
      run_op(MDU_MULT, 32'd3, 32'd5, lat, bsy);
      check("mult_clears_dbz", div_by_zero, 0);
      check("mult_small_lo", lo, 32'd15);

      // start and mthi during CALC are ignored
      op = MDU_MULT; rs_val = 32'h0001_2345; rt_val = 32'h10; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         lat++;
      end
      check("calc_hi_hold", hi, 32'd0);
      op = MDU_DIV; rs_val = 32'd9; rt_val = 32'd0; start = 1'b1; wr_hi = 1'b1; wr_data = 32'hDEAD;
      tick();
      lat++;
      start = 1'b0; wr_hi = 1'b0;
      check("ignored_busy", busy, 1);
      wait_done(bsy, bsy);
      lat = lat + bsy;
      check("ignored_lat", lat, 33);
      check("ignored_hi", hi, 32'd0);
      check("ignored_lo", lo, 32'h0012_3450);
      check("ignored_dbz", div_by_zero, 0);

      // reset mid-operation
      op = MDU_MULTU; rs_val = 32'd1000; rt_val = 32'd1000; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hi", hi, 0);
      check("midrst_lo", lo, 0);
      check("midrst_state", dbg_state, 0);
      tick();
      check("midrst_stays_idle", busy, 0);

      // mthi/mtlo in IDLE, then a start that drops a concurrent mtlo
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hAAAA_5555;
      tick();
      wr_hi = 1'b0; wr_lo = 1'b0;
      check("mthi", hi, 32'hAAAA_5555);
      check("mtlo", lo, 32'hAAAA_5555);
      wr_lo = 1'b1; wr_data = 32'h0000_0005;
      tick();
      wr_lo = 1'b0;
      check("mtlo_only_lo", lo, 32'h0000_0005);
      check("mtlo_only_hi", hi, 32'hAAAA_5555);
      op = MDU_MULTU; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
      wr_lo = 1'b1; wr_data = 32'h1111_1111;
      tick();
      start = 1'b0; wr_lo = 1'b0;
      check("drop_wr_lo", lo, 32'h0000_0005);
      check("drop_busy", busy, 1);
      wait_done(lat, bsy);
      check("drop_lat", lat, 33);
      check("drop_res_lo", lo, 32'd42);
      check("drop_res_hi", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
